trig_pulse_gen: RTL and testbench

TRIG_PULSE_GEN -- requirements
Module: trig_pulse_gen

---
 rtl/trig_pulse_gen_pkg.sv | 22 ++
 rtl/trig_pulse_gen_echo_sync.sv | 26 ++
 rtl/trig_pulse_gen.sv | 103 ++++++++++
 tb/tb_trig_pulse_gen.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/trig_pulse_gen_pkg.sv
// trig_pulse_gen_pkg: shared state encodings, parameter defaults, counter widths and clamp helpers
package trig_pulse_gen_pkg;
  localparam int PERIOD_W = 16;
  localparam int WIDTH_W = 14;
  localparam int COUNT_W = 16;
  localparam int DELAY_W = 16;
  localparam int ECHO_TIMEOUT_DEF = 4096;
  localparam int SYNC_STAGES_DEF = 2;
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    HIGH = 3'b010,
    LOW  = 3'b100
  } state_t;
  // A zero width still produces a one-cycle pulse
  function automatic logic [PERIOD_W-1:0] eff_width(input logic [WIDTH_W-1:0] w);
    return (w == '0) ? PERIOD_W'(1) : PERIOD_W'(w);
  endfunction
  // The low phase never shrinks below one cycle
  function automatic logic [PERIOD_W-1:0] eff_period(input logic [PERIOD_W-1:0] p, input logic [PERIOD_W-1:0] w);
    return (p <= w) ? w + PERIOD_W'(1) : p;
  endfunction
endpackage

// File: rtl/trig_pulse_gen_echo_sync.sv
// echo_sync: multi-flop synchronizer for the asynchronous echo followed by a registered rising-edge detect
module echo_sync
  import trig_pulse_gen_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic hardreset,
  input  logic echo_in,
  output logic echo_rise
);
  logic [SYNC_STAGES-1:0] sync;
  logic last;
  // Shift the echo through the synchronizer and flag a fresh high level for one cycle
  always_ff @(posedge clk or negedge hardreset) begin
    if (!hardreset) begin
      sync <= '0;
      last <= 1'b0;
      echo_rise <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], echo_in};
      last <= sync[SYNC_STAGES-1];
      echo_rise <= sync[SYNC_STAGES-1] & ~last;
    end
  end
endmodule

// File: rtl/trig_pulse_gen.sv
// trig_pulse_gen: burst trigger sequencer with echo round-trip delay measurement and timeout
module trig_pulse_gen
  import trig_pulse_gen_pkg::*;
#(
  parameter int ECHO_TIMEOUT = ECHO_TIMEOUT_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                clk,
  input  logic                hardreset,
  input  logic                start,
  input  logic                stop,
  input  logic [PERIOD_W-1:0] period,
  input  logic [WIDTH_W-1:0]  width,
  input  logic [COUNT_W-1:0]  count,
  output logic                trig_out,
  input  logic                echo_in,
  output logic                busy,
  output logic                done,
  output logic [DELAY_W-1:0]  meas_delay,
  output logic                meas_valid,
  output logic                timeout_err
);
  localparam logic [DELAY_W-1:0] TO_LAST = DELAY_W'(ECHO_TIMEOUT - 1);
  state_t state, state_n;
  logic [PERIOD_W-1:0] p_sh, w_sh, ph_cnt;
  logic [COUNT_W-1:0] c_sh, p_cnt;
  logic [DELAY_W-1:0] dcnt;
  logic rdy, stop_pend, armed, echo_rise;
  logic go, high_end, low_end, more, done_n, trig_rise, hit, expire;
  assign busy = state != IDLE;
  assign go = state == IDLE && rdy && start && !stop;
  assign high_end = ph_cnt == w_sh - PERIOD_W'(1);
  assign low_end = ph_cnt == p_sh - w_sh - PERIOD_W'(1);
  assign more = c_sh == '0 || p_cnt != c_sh;
  assign trig_rise = state_n == HIGH && !trig_out;
  assign hit = armed && echo_rise;
  assign expire = armed && !echo_rise && (trig_rise || dcnt == TO_LAST);
  echo_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .hardreset(hardreset),
    .echo_in(echo_in),
    .echo_rise(echo_rise)
  );
  // Next state and burst-completion decode; stop in HIGH waits for the phase end, stop in LOW acts at once
  always_comb begin
    done_n = (state == HIGH && high_end && (stop || stop_pend)) || (state == LOW && (stop || (low_end && !more)));
    state_n = state == IDLE ? (go ? HIGH : IDLE) : done_n ? IDLE : state == HIGH ? (high_end ? LOW : HIGH) : (low_end ? HIGH : LOW);
  end
  // State register with registered trigger and completion strobe; rdy holds off start for one edge after reset
  always_ff @(posedge clk or negedge hardreset) begin
    if (!hardreset) begin
      state <= IDLE;
      trig_out <= 1'b0;
      done <= 1'b0;
      rdy <= 1'b0;
      stop_pend <= 1'b0;
    end else begin
      state <= state_n;
      trig_out <= state_n == HIGH;
      done <= done_n;
      rdy <= 1'b1;
      stop_pend <= state == HIGH && !high_end && (stop_pend || stop);
    end
  end
  // Phase length counter restarts on every state change; pulse counter advances at each high-phase end
  always_ff @(posedge clk or negedge hardreset) begin
    if (!hardreset) begin
      ph_cnt <= '0;
      p_cnt <= '0;
    end else begin
      ph_cnt <= (state_n != state || state == IDLE) ? '0 : ph_cnt + PERIOD_W'(1);
      p_cnt <= go ? '0 : (state == HIGH && high_end) ? p_cnt + COUNT_W'(1) : p_cnt;
    end
  end
  // Settings are captured only when a burst is accepted so later input changes are ignored
  always_ff @(posedge clk or negedge hardreset) begin
    if (!hardreset) begin
      w_sh <= '0;
      p_sh <= '0;
      c_sh <= '0;
    end else if (go) begin
      w_sh <= eff_width(width);
      p_sh <= eff_period(period, eff_width(width));
      c_sh <= count;
    end
  end
  // Each trigger rise arms a fresh delay count; echo captures it, timeout or a new rise abandons it
  always_ff @(posedge clk or negedge hardreset) begin
    if (!hardreset) begin
      armed <= 1'b0;
      dcnt <= '0;
      meas_delay <= '0;
      meas_valid <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      armed <= trig_rise || (armed && !echo_rise && !expire);
      dcnt <= trig_rise ? '0 : armed ? dcnt + DELAY_W'(1) : dcnt;
      meas_delay <= hit ? dcnt : meas_delay;
      meas_valid <= hit;
      timeout_err <= expire;
    end
  end
endmodule

// File: tb/tb_trig_pulse_gen.sv
// tb_trig_pulse_gen: directed bursts with a scoreboard of expected event cycles checked by a monitor
module tb_trig_pulse_gen;
  localparam int ECHO_DLY = 100;
  localparam int SYNC = 2;
  localparam int TO2 = 64;
  typedef struct {
    int cyc;
    int val;
  } meas_t;
  logic clk = 1'b0;
  logic hardreset, start, stop, loop_en;
  logic [15:0] period;
  logic [13:0] width;
  logic [15:0] count;
  logic trig_out, busy, done, meas_valid, timeout_err, echo;
  logic [15:0] meas_delay;
  logic trig2, busy2, done2, meas_valid2, timeout_err2;
  logic [15:0] meas_delay2;
  logic [ECHO_DLY-1:0] dly = '0;
  logic prev_trig;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int q_rise[$], q_fall[$], q_done[$], q_to1[$], q_to2[$];
  meas_t q_meas[$];
  assign echo = loop_en & dly[ECHO_DLY-1];
  trig_pulse_gen u_dut (
    .clk(clk), .hardreset(hardreset), .start(start), .stop(stop),
    .period(period), .width(width), .count(count), .trig_out(trig_out),
    .echo_in(echo), .busy(busy), .done(done), .meas_delay(meas_delay),
    .meas_valid(meas_valid), .timeout_err(timeout_err)
  );
  trig_pulse_gen #(.ECHO_TIMEOUT(TO2)) u_to (
    .clk(clk), .hardreset(hardreset), .start(start), .stop(stop),
    .period(period), .width(width), .count(count), .trig_out(trig2),
    .echo_in(1'b0), .busy(busy2), .done(done2), .meas_delay(meas_delay2),
    .meas_valid(meas_valid2), .timeout_err(timeout_err2)
  );
  always #5 clk = ~clk;
  // Cycle stamp and the 100-cycle echo loopback line
  always @(posedge clk) begin
    cyc <= cyc + 1;
    dly <= {dly[ECHO_DLY-2:0], trig_out};
  end
  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic unexpected(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got an event at cycle %0d, required none", name, cyc);
  endtask
  // Monitor: pops the expected cycle for every output event the DUTs present
  initial begin
    meas_t m;
    prev_trig = 1'b0;
    forever begin
      @(negedge clk);
      if (hardreset) begin
        if (trig_out && !prev_trig) begin
          if (q_rise.size() == 0) unexpected("trig_out rise");
          else check("trig_out rise cycle", cyc, q_rise.pop_front());
          check("busy at rise", int'(busy), 1);
          check("twin trig_out at rise", int'(trig2), 1);
        end
        if (!trig_out && prev_trig) begin
          if (q_fall.size() == 0) unexpected("trig_out fall");
          else check("trig_out fall cycle", cyc, q_fall.pop_front());
        end
        if (done) begin
          if (q_done.size() == 0) unexpected("done");
          else check("done cycle", cyc, q_done.pop_front());
          check("busy with done", int'(busy), 0);
          check("twin done", int'(done2), 1);
        end
        if (meas_valid) begin
          if (q_meas.size() == 0) unexpected("meas_valid");
          else begin
            m = q_meas.pop_front();
            check("meas_valid cycle", cyc, m.cyc);
            check("meas_delay value", int'(meas_delay), m.val);
          end
        end
        if (timeout_err) begin
          if (q_to1.size() == 0) unexpected("timeout_err");
          else check("timeout_err cycle", cyc, q_to1.pop_front());
        end
        if (timeout_err2) begin
          if (q_to2.size() == 0) unexpected("timeout_err (64)");
          else check("timeout_err (64) cycle", cyc, q_to2.pop_front());
        end
        if (meas_valid2) unexpected("meas_valid with echo tied low");
      end
      prev_trig = trig_out;
    end
  end
  task automatic do_reset();
    @(negedge clk);
    #2 hardreset = 1'b0;
    @(negedge clk);
    #2 hardreset = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic drained(input string tag);
    check({tag, " rise queue"}, q_rise.size(), 0);
    check({tag, " fall queue"}, q_fall.size(), 0);
    check({tag, " done queue"}, q_done.size(), 0);
    check({tag, " meas queue"}, q_meas.size(), 0);
    check({tag, " timeout queue"}, q_to1.size(), 0);
    check({tag, " timeout (64) queue"}, q_to2.size(), 0);
  endtask
  // One burst: raw inputs, expected effective width/period, pulses emitted, stop and done offsets from the start edge
  task automatic run(input string tag, input int w, input int p, input int n, input int we, input int pe,
                     input int np, input int stop_off, input int done_off, input bit lp);
    int s1, r;
    meas_t m;
    loop_en = lp;
    @(negedge clk);
    width = 14'(w);
    period = 16'(p);
    count = 16'(n);
    start = 1'b1;
    s1 = cyc + 1;
    for (int i = 0; i < np; i++) begin
      r = s1 + i * pe;
      q_rise.push_back(r);
      q_fall.push_back(r + we);
      if (lp) begin
        m.cyc = r + ECHO_DLY + SYNC + 2;
        m.val = ECHO_DLY + SYNC + 1;
        q_meas.push_back(m);
      end else if (i > 0) q_to1.push_back(r);
      q_to2.push_back((i < np - 1 && pe < TO2) ? r + pe : r + TO2);
    end
    q_done.push_back(s1 + done_off);
    @(negedge clk);
    start = 1'b0;
    width = 14'd1;
    period = 16'd3;
    count = 16'd1;
    if (stop_off >= 0) begin
      while (cyc < s1 + stop_off - 1) @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
    end
    while (cyc < s1 + done_off + 150) @(negedge clk);
    drained(tag);
    check({tag, " meas_delay with echo low"}, int'(meas_delay2), 0);
    loop_en = 1'b0;
    do_reset();
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
  // Directed sequence
  initial begin
    int s1;
    hardreset = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    loop_en = 1'b0;
    period = '0;
    width = '0;
    count = '0;
    repeat (3) @(negedge clk);
    #2;
    check("reset trig_out", int'(trig_out), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset meas_valid", int'(meas_valid), 0);
    check("reset timeout_err", int'(timeout_err), 0);
    check("reset meas_delay", int'(meas_delay), 0);
    check("reset twin trig_out", int'(trig2), 0);
    width = 14'd10;
    period = 16'd40;
    count = 16'd3;
    hardreset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("start on first edge after reset ignored", int'(busy), 0);
    run("burst", 10, 40, 3, 10, 40, 3, -1, 120, 1'b0);
    run("clamp zero", 0, 0, 2, 1, 2, 2, -1, 4, 1'b0);
    run("clamp period", 10, 5, 2, 10, 11, 2, -1, 22, 1'b0);
    run("echo", 10, 200, 3, 10, 200, 3, -1, 600, 1'b1);
    run("echo after done", 10, 50, 1, 10, 50, 1, -1, 50, 1'b1);
    run("stop high", 10, 40, 0, 10, 40, 3, 84, 90, 1'b0);
    run("stop low", 5, 20, 0, 5, 20, 1, 8, 8, 1'b0);
    @(negedge clk);
    width = 14'd4;
    period = 16'd10;
    count = 16'd2;
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    repeat (10) @(negedge clk);
    check("start+stop busy", int'(busy), 0);
    check("start+stop trig_out", int'(trig_out), 0);
    drained("start+stop");
    @(negedge clk);
    width = 14'd10;
    period = 16'd40;
    count = 16'd3;
    start = 1'b1;
    s1 = cyc + 1;
    q_rise.push_back(s1);
    @(negedge clk);
    start = 1'b0;
    while (cyc < s1 + 3) @(negedge clk);
    check("mid-high trig_out before reset", int'(trig_out), 1);
    #2 hardreset = 1'b0;
    #1;
    check("reset mid-high trig_out", int'(trig_out), 0);
    check("reset mid-high busy", int'(busy), 0);
    check("reset mid-high done", int'(done), 0);
    check("reset mid-high meas_valid", int'(meas_valid), 0);
    check("reset mid-high timeout_err", int'(timeout_err), 0);
    check("reset mid-high meas_delay", int'(meas_delay), 0);
    check("reset mid-high twin busy", int'(busy2), 0);
    @(negedge clk);
    #2 hardreset = 1'b1;
    repeat (2) @(negedge clk);
    drained("reset mid-high");
    run("after reset", 3, 8, 2, 3, 8, 2, -1, 16, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
